// File: rtl/cp0_unit_pkg.sv
// Shared CP0 constants: exception codes, register numbers and SR/Cause field positions.
package cp0_unit_pkg;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12,
    EXC_NONE = 5'd31
  } exc_code_e;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int unsigned SR_IE_BIT      = 0;
  localparam int unsigned SR_EXL_BIT     = 1;
  localparam int unsigned IM_IP_LO       = 10;
  localparam int unsigned IM_IP_HI       = 15;
  localparam int unsigned CAUSE_EXC_LO   = 2;
  localparam int unsigned CAUSE_EXC_HI   = 6;
  localparam int unsigned CAUSE_BD_BIT   = 31;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// M-stage <-> CP0 signal bundle: mtc0/mfc0 access, exception inputs, redirect outputs.
interface cp0_unit_if;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        is_bd;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        eret_m;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  modport master (
    output cp0_we, cp0_addr, cp0_wdata, vpc, is_bd, exc_code, hw_int, eret_m,
    input  cp0_rdata, req, handler_pc, epc_out
  );

  modport slave (
    input  cp0_we, cp0_addr, cp0_wdata, vpc, is_bd, exc_code, hw_int, eret_m,
    output cp0_rdata, req, handler_pc, epc_out
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt-vs-exception arbitration and
// the flush/redirect request for the M stage.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h0000_0007,
  parameter logic [31:0] HANDLER  = 32'h0000_4180
) (
  input  logic       clk,
  input  logic       reset,
  cp0_unit_if.slave  bus
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [4:0]  taken_code;
  logic [31:0] victim_epc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Raw hw_int (not the registered IP) so an interrupt is taken the cycle it arrives.
  always_comb begin
    int_req    = (|(bus.hw_int & sr_im)) & sr_ie & ~sr_exl;
    exc_req    = (bus.exc_code != EXC_NONE) & ~sr_exl;
    req        = int_req | exc_req;
    taken_code = int_req ? EXC_INT : bus.exc_code;
    victim_epc = word_align(bus.is_bd ? (bus.vpc - 32'd4) : bus.vpc);
  end

  always_comb begin
    sr_word                       = '0;
    sr_word[IM_IP_HI:IM_IP_LO]    = sr_im;
    sr_word[SR_EXL_BIT]           = sr_exl;
    sr_word[SR_IE_BIT]            = sr_ie;
    cause_word                    = '0;
    cause_word[CAUSE_BD_BIT]      = cause_bd;
    cause_word[IM_IP_HI:IM_IP_LO] = cause_ip;
    cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
  end

  always_comb begin
    case (bus.cp0_addr)
      REG_SR:    bus.cp0_rdata = sr_word;
      REG_CAUSE: bus.cp0_rdata = cause_word;
      REG_EPC:   bus.cp0_rdata = epc;
      REG_PRID:  bus.cp0_rdata = PRID_VAL;
      default:   bus.cp0_rdata = '0;
    endcase
  end

  assign bus.req        = req;
  assign bus.handler_pc = HANDLER;
  assign bus.epc_out    = epc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= bus.hw_int;
      // A taken request suppresses any same-cycle mtc0 or eret.
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bus.is_bd;
        cause_exc <= taken_code;
        epc       <= victim_epc;
      end else begin
        if (bus.cp0_we) begin
          case (bus.cp0_addr)
            REG_SR: begin
              sr_im  <= bus.cp0_wdata[IM_IP_HI:IM_IP_LO];
              sr_exl <= bus.cp0_wdata[SR_EXL_BIT];
              sr_ie  <= bus.cp0_wdata[SR_IE_BIT];
            end
            REG_EPC: epc <= word_align(bus.cp0_wdata);
            default: ;
          endcase
        end
        if (bus.eret_m) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_unit;
  import cp0_unit_pkg::*;

  logic clk;
  logic reset;
  cp0_unit_if bus();

  cp0_unit #(
    .PRID_VAL(32'h0000_0007),
    .HANDLER (32'h0000_4180)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_RDATA = 0;
  localparam int K_REQ   = 1;
  localparam int K_EPC   = 2;
  localparam int K_HPC   = 3;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  exp_t        mon_e;
  logic [31:0] mon_got;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_RDATA: mon_got = bus.cp0_rdata;
        K_REQ:   mon_got = {31'd0, bus.req};
        K_EPC:   mon_got = bus.epc_out;
        default: mon_got = bus.handler_pc;
      endcase
      nvec++;
      if (mon_got !== mon_e.val) begin
        nerr++;
        $display("FAIL %s: got %h, expected %h", mon_e.name, mon_got, mon_e.val);
      end
    end
  end

  task automatic push(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                       input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                       input logic [5:0] hw, input logic eret);
    bus.cp0_we    = we;
    bus.cp0_addr  = addr;
    bus.cp0_wdata = wdata;
    bus.vpc       = vpc;
    bus.is_bd     = bd;
    bus.exc_code  = exc;
    bus.hw_int    = hw;
    bus.eret_m    = eret;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;

    // Reset state
    drive(1'b0, REG_SR, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h0, "rst_sr");
    push(K_REQ, 32'h0, "rst_req");
    push(K_EPC, 32'h0, "rst_epc");
    push(K_HPC, 32'h0000_4180, "handler_pc");
    tick();
    drive(1'b0, REG_CAUSE, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h0, "rst_cause");
    tick();
    drive(1'b0, REG_EPC, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h0, "rst_epc_rd");
    tick();
    drive(1'b0, REG_PRID, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h7, "prid");
    tick();

    // mtc0 SR, then RI exception; read shows pre-write value
    drive(1'b1, REG_SR, 32'h0000_fc01, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h0, "sr_no_bypass");
    push(K_REQ, 32'h0, "mtc0_req");
    tick();
    drive(1'b0, REG_SR, 32'h0, 32'h3010, 1'b0, EXC_RI, 6'b0, 1'b0);
    push(K_RDATA, 32'h0000_fc01, "sr_written");
    push(K_REQ, 32'h1, "ri_req");
    tick();
    drive(1'b0, REG_CAUSE, 32'h0, 32'h3010, 1'b0, EXC_RI, 6'b0, 1'b0);
    push(K_RDATA, 32'h0000_0028, "cause_ri");
    push(K_REQ, 32'h0, "nested_ri_masked");
    push(K_EPC, 32'h3010, "epc_ri");
    tick();
    drive(1'b0, REG_SR, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h0000_fc03, "sr_exl_set");
    tick();

    // eret with a pending enabled interrupt; int beats Ov in a delay slot
    drive(1'b0, REG_EPC, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b000001, 1'b1);
    push(K_RDATA, 32'h3010, "epc_rd");
    push(K_REQ, 32'h0, "eret_cycle_req");
    tick();
    drive(1'b0, REG_CAUSE, 32'h0, 32'h3024, 1'b1, EXC_OV, 6'b000001, 1'b0);
    push(K_RDATA, 32'h0000_0428, "cause_ip_tracked");
    push(K_REQ, 32'h1, "int_after_eret");
    tick();
    drive(1'b0, REG_CAUSE, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h8000_0400, "cause_int_bd");
    push(K_EPC, 32'h3020, "epc_bd");
    push(K_REQ, 32'h0, "exl_masks");
    tick();
    drive(1'b1, REG_SR, 32'h0000_fc01, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h0000_fc03, "sr_before_clr");
    tick();

    // mtc0 EPC colliding with an exception: exception wins
    drive(1'b1, REG_EPC, 32'h3457, 32'h3106, 1'b0, EXC_ADEL, 6'b0, 1'b0);
    push(K_RDATA, 32'h3020, "epc_pre_collide");
    push(K_REQ, 32'h1, "adel_req");
    tick();
    drive(1'b1, REG_SR, 32'h0000_fc01, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_EPC, 32'h3104, "epc_req_wins");
    push(K_RDATA, 32'h0000_fc03, "sr_after_adel");
    tick();
    drive(1'b1, REG_EPC, 32'h3457, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_REQ, 32'h0, "epc_wr_req");
    tick();
    drive(1'b0, REG_EPC, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h3454, "epc_mtc0_aligned");
    push(K_EPC, 32'h3454, "epc_out_mtc0");
    tick();
    drive(1'b1, REG_CAUSE, 32'hffff_ffff, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h0000_0010, "cause_adel");
    tick();
    drive(1'b1, REG_PRID, 32'hffff_ffff, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h7, "prid_ro");
    tick();
    drive(1'b0, REG_CAUSE, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h0000_0010, "cause_wr_ignored");
    tick();

    // IE=0: IP tracks hw_int one cycle late, no request
    drive(1'b1, REG_SR, 32'h0000_fc00, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h0000_fc01, "sr_before_ie0");
    tick();
    drive(1'b0, REG_CAUSE, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b101010, 1'b0);
    push(K_RDATA, 32'h0000_0010, "ip_lag");
    push(K_REQ, 32'h0, "ie0_req_a");
    tick();
    drive(1'b0, REG_CAUSE, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b010101, 1'b0);
    push(K_RDATA, 32'h0000_a810, "ip_101010");
    push(K_REQ, 32'h0, "ie0_req_b");
    tick();
    drive(1'b0, REG_CAUSE, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h0000_5410, "ip_010101");
    tick();

    // IM masking, then reset mid-handler
    drive(1'b1, REG_SR, 32'h0000_0401, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h0000_fc00, "sr_ie0");
    tick();
    drive(1'b0, REG_SR, 32'h0, 32'h3200, 1'b0, EXC_NONE, 6'b000010, 1'b0);
    push(K_RDATA, 32'h0000_0401, "sr_im0");
    push(K_REQ, 32'h0, "im_masked");
    tick();
    drive(1'b0, REG_SR, 32'h0, 32'h3200, 1'b0, EXC_NONE, 6'b000011, 1'b0);
    push(K_REQ, 32'h1, "im_enabled");
    tick();
    reset = 1'b0;
    drive(1'b0, REG_SR, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b000011, 1'b0);
    push(K_RDATA, 32'h0000_0403, "sr_in_handler");
    push(K_EPC, 32'h3200, "epc_int");
    push(K_REQ, 32'h0, "handler_req");
    tick();
    reset = 1'b1;
    drive(1'b0, REG_SR, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h0, "sr_after_rst");
    push(K_EPC, 32'h0, "epc_after_rst");
    push(K_REQ, 32'h0, "req_after_rst");
    tick();
    drive(1'b0, REG_CAUSE, 32'h0, 32'h0, 1'b0, EXC_NONE, 6'b0, 1'b0);
    push(K_RDATA, 32'h0, "cause_after_rst");
    tick();

    tick();
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
